// File: rtl/ring_counter_pkg.sv
// ring_counter_pkg
//   Shared constants and helpers for the one-hot ring counter.
//   DEF_WIDTH / DEF_SEED : default ring size and reset/correction seed.
//   ONEHOT_W             : width the one-hot checker works at. Callers
//                          zero-extend their vector to it, so WIDTH <= 64.
//   is_onehot(v)         : 1 when exactly one bit of v is set.
package ring_counter_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_SEED  = 1;
    localparam int ONEHOT_W  = 64;

    function automatic logic is_onehot(input logic [ONEHOT_W-1:0] v);
        return $countones(v) == 1;
    endfunction

endpackage

// File: rtl/ring_counter.sv
// ring_counter
//   One-hot ring counter used as a phase/slot sequencer. A single 1
//   circulates through WIDTH positions, one step per enabled clock.
//   Illegal states (zero or several bits set) fall back to SEED.
//
//   Ports
//     clock      : rising-edge system clock
//     reset      : asynchronous active-low reset (out=SEED, wrap=0)
//     en         : rotate this cycle
//     dir        : 0 = left (bit i -> i+1), 1 = right
//     load       : synchronous parallel load, highest priority
//     load_value : value to load; a non one-hot value loads SEED instead
//     out        : registered ring state
//     wrap       : registered pulse for the cycle after the 1 wraps
//     err        : (RING_COUNTER_ERR_EN only) one-cycle pulse when a
//                  correction fires or an illegal load_value is loaded
//
//   Build option: define RING_COUNTER_ERR_EN to add the err output.
module ring_counter
    import ring_counter_pkg::*;
#(
    parameter int               WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] out,
`ifdef RING_COUNTER_ERR_EN
    output logic             err,
`endif
    output logic             wrap
);

    logic [WIDTH-1:0] out_q, out_d;
    logic             wrap_q, wrap_d;
    logic             load_ok, cur_ok;

`ifdef RING_COUNTER_ERR_EN
    logic             err_q, err_d;
`endif

    // One checker shared by the load path and the self-correction path.
    assign load_ok = is_onehot(ONEHOT_W'(load_value));
    assign cur_ok  = is_onehot(ONEHOT_W'(out_q));

    // Priority: load > correction > rotate > hold. wrap only survives one
    // cycle, so it defaults to 0 on every path that is not a wrapping rotate.
    always_comb begin
        out_d  = out_q;
        wrap_d = 1'b0;
`ifdef RING_COUNTER_ERR_EN
        err_d  = 1'b0;
`endif
        if (load) begin
            out_d = load_ok ? load_value : SEED;
`ifdef RING_COUNTER_ERR_EN
            err_d = ~load_ok;
`endif
        end else if (!cur_ok) begin
            out_d = SEED;
`ifdef RING_COUNTER_ERR_EN
            err_d = 1'b1;
`endif
        end else if (en) begin
            if (!dir) begin
                out_d  = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
                wrap_d = out_q[WIDTH-1];
            end else begin
                out_d  = {out_q[0], out_q[WIDTH-1:1]};
                wrap_d = out_q[0];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_q  <= SEED;
            wrap_q <= 1'b0;
`ifdef RING_COUNTER_ERR_EN
            err_q  <= 1'b0;
`endif
        end else begin
            out_q  <= out_d;
            wrap_q <= wrap_d;
`ifdef RING_COUNTER_ERR_EN
            err_q  <= err_d;
`endif
        end
    end

    assign out  = out_q;
    assign wrap = wrap_q;
`ifdef RING_COUNTER_ERR_EN
    assign err  = err_q;
`endif

endmodule

// File: tb/tb_ring_counter.sv
// tb_ring_counter
//   Directed plus random stimulus against a slot-index reference model:
//   the model tracks which slot holds the token (an integer) and derives
//   the expected one-hot vector, wrap and err from that.
//   Build option: define RING_COUNTER_ERR_EN to also check err.
module tb_ring_counter;

    localparam int W = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b0, dir = 1'b0, load = 1'b0;
    logic [W-1:0] load_value = '0;
    logic [W-1:0] out;
    logic         wrap;
`ifdef RING_COUNTER_ERR_EN
    logic         err;
`endif

    ring_counter dut (
        .clock      (clock),
        .reset      (reset),
        .en         (en),
        .dir        (dir),
        .load       (load),
        .load_value (load_value),
        .out        (out),
`ifdef RING_COUNTER_ERR_EN
        .err        (err),
`endif
        .wrap       (wrap)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state: token slot, expected flags, pending illegal state.
    int   m_pos     = 0;
    logic m_wrap    = 1'b0;
    logic m_err     = 1'b0;
    logic m_illegal = 1'b0;

    function automatic int onehot_idx(input logic [W-1:0] v);
        int n   = 0;
        int idx = -1;
        for (int i = 0; i < W; i++) if (v[i]) begin n++; idx = i; end
        return (n == 1) ? idx : -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out"}, 32'(out), 32'(1) << m_pos);
        chk({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
`ifdef RING_COUNTER_ERR_EN
        chk({tag, ".err"}, 32'(err), 32'(m_err));
`endif
    endtask

    // Called at a falling edge: drive inputs, advance model, check after the rise.
    task automatic step(input logic e, input logic d, input logic l,
                        input logic [W-1:0] lv, input string tag);
        int idx;
        en = e; dir = d; load = l; load_value = lv;
        m_wrap = 1'b0;
        m_err  = 1'b0;
        if (l) begin
            idx = onehot_idx(lv);
            m_pos = (idx < 0) ? 0 : idx;
            m_err = (idx < 0);
        end else if (m_illegal) begin
            m_pos = 0;
            m_err = 1'b1;
        end else if (e) begin
            if (!d) begin
                m_wrap = (m_pos == W - 1);
                m_pos  = (m_pos + 1) % W;
            end else begin
                m_wrap = (m_pos == 0);
                m_pos  = (m_pos + W - 1) % W;
            end
        end
        m_illegal = 1'b0;
        @(posedge clock);
        #1;
        check_all(tag);
        @(negedge clock);
    endtask

    initial begin
        // Async reset with the clock running, no edge needed to take effect.
        #1 reset = 1'b0;
        #1;
        m_pos = 0; m_wrap = 0; m_err = 0;
        check_all("reset_async");
        @(posedge clock); #1;
        check_all("reset_held");
        @(negedge clock);
        reset = 1'b1;

        // Left rotation, two full laps; wrap on each 1000->0001.
        for (int i = 0; i < 8; i++) step(1, 0, 0, '0, "left");
        step(1, 0, 0, '0, "left_to_0010");
        step(1, 0, 0, '0, "left_to_0100");

        // Right rotation from 0100, then hold at 1000.
        for (int i = 0; i < 3; i++) step(1, 1, 0, '0, "right");
        for (int i = 0; i < 3; i++) step(0, 1, 0, '0, "hold");

        // Loads beat enable; an illegal value falls back to the seed.
        step(1, 0, 1, 4'b0100, "load_legal");
        step(1, 1, 1, 4'b0110, "load_illegal");
        step(1, 0, 1, 4'b0000, "load_zero");
        step(1, 0, 1, 4'b1000, "load_msb");
        step(0, 0, 0, '0, "hold_after_load");

        // Async reset mid-count at 1000, between edges.
        #2 reset = 1'b0;
        #1;
        m_pos = 0; m_wrap = 0; m_err = 0;
        check_all("reset_mid");
        @(posedge clock); #1;
        check_all("reset_mid_held");
        @(negedge clock);
        reset = 1'b1;
        step(1, 0, 0, '0, "after_reset");

        // Self-correction from illegal internal states, en low.
        force dut.out_q = 4'b1010;
        #1 release dut.out_q;
        m_illegal = 1'b1;
        step(0, 0, 0, '0, "correct_1010");
        force dut.out_q = 4'b0000;
        #1 release dut.out_q;
        m_illegal = 1'b1;
        step(1, 1, 0, '0, "correct_0000");
        step(1, 1, 0, '0, "after_correct");

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
                 W'($urandom), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1);
    end

endmodule
